// File: rtl/vga_fb_controller.sv
// Bus-mapped port-A owner for the 1-bpp 320x240 frame buffer: pixel writes, colour config, fill engine.
// Optional macro FB_READBACK_EN enables pixel readback through offset +3.
//   state | meaning
//   IDLE  | no fill running
//   RUN   | fill engine walking the frame, stalls while CPU owns port A
//   DONE  | last pixel written, FILL_DONE pulse
module vga_fb_controller #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         X_MAX     = 319,
  parameter int         Y_MAX     = 239,
  parameter logic [7:0] FG_RESET  = 8'hFF,
  parameter logic [7:0] BG_RESET  = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  input  logic [7:0]  BUS_DATA_IN,
  input  logic        BUS_WE,
  input  logic        BUS_RE,
  output logic [7:0]  BUS_DATA_OUT,
  output logic        BUS_DATA_OE,
  output logic [16:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  input  logic        FB_RD_DATA,
  output logic [15:0] CONFIG_COLOURS,
  output logic        FILL_DONE
);

  localparam logic [8:0] X_LAST = X_MAX[8:0];
  localparam logic [7:0] Y_LAST = Y_MAX[7:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_t;

  fill_state_t state, state_next;

  logic [8:0]  x_reg;
  logic [7:0]  y_reg;
  logic [7:0]  fg_reg, bg_reg;
  logic        err;
  logic        status_rd_q;
  logic        pend_valid, pend_data;
  logic [16:0] pend_addr;
  logic [8:0]  fill_x;
  logic [7:0]  fill_y;
  logic        fill_val;
  logic        fill_we;
  logic        rb_port;

  // 9-bit subtraction so addresses below BASE_ADDR wrap far out of range
  logic [8:0] addr_diff;
  logic       hit, wr, rd, coord_ok, pix_wr, start_fill, busy;
  logic [2:0] offset;
  logic [7:0] rd_mux;

  assign addr_diff  = {1'b0, BUS_ADDR} - {1'b0, BASE_ADDR};
  assign hit        = addr_diff < 9'd8;
  assign offset     = addr_diff[2:0];
  assign wr         = BUS_WE && hit;
  assign rd         = BUS_RE && hit;
  assign coord_ok   = (x_reg <= X_LAST) && (y_reg <= Y_LAST);
  assign pix_wr     = wr && (offset == 3'd3);
  assign busy       = (state != IDLE);
  assign start_fill = wr && (offset == 3'd6) && BUS_DATA_IN[0] && !busy;

  assign CONFIG_COLOURS = {fg_reg, bg_reg};

  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      3'd0:    rd_mux = x_reg[7:0];
      3'd1:    rd_mux = {7'b0, x_reg[8]};
      3'd2:    rd_mux = y_reg;
      3'd4:    rd_mux = fg_reg;
      3'd5:    rd_mux = bg_reg;
      3'd7:    rd_mux = {6'b0, err, busy};
      default: rd_mux = 8'h00;
    endcase
  end

`ifdef FB_READBACK_EN
  logic rb_rd, rb_q, rb_bad_q;
  assign rb_rd   = rd && (offset == 3'd3);
  assign rb_port = rb_rd && coord_ok;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rb_q         <= 1'b0;
      rb_bad_q     <= 1'b0;
      BUS_DATA_OUT <= 8'h00;
      BUS_DATA_OE  <= 1'b0;
    end else begin
      rb_q     <= rb_rd;
      rb_bad_q <= rb_rd && !coord_ok;
      if (rb_q) begin
        BUS_DATA_OUT <= rb_bad_q ? 8'h00 : {7'b0, FB_RD_DATA};
        BUS_DATA_OE  <= 1'b1;
      end else if (rd && !rb_rd) begin
        BUS_DATA_OUT <= rd_mux;
        BUS_DATA_OE  <= 1'b1;
      end else begin
        BUS_DATA_OUT <= 8'h00;
        BUS_DATA_OE  <= 1'b0;
      end
    end
  end
`else
  logic rb_rd;
  logic unused_fb_rd;
  assign rb_rd        = 1'b0;
  assign rb_port      = 1'b0;
  assign unused_fb_rd = FB_RD_DATA;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      BUS_DATA_OUT <= 8'h00;
      BUS_DATA_OE  <= 1'b0;
    end else begin
      BUS_DATA_OUT <= rd ? rd_mux : 8'h00;
      BUS_DATA_OE  <= rd;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x_reg       <= 9'd0;
      y_reg       <= 8'd0;
      fg_reg      <= FG_RESET;
      bg_reg      <= BG_RESET;
      err         <= 1'b0;
      status_rd_q <= 1'b0;
      pend_valid  <= 1'b0;
      pend_addr   <= 17'd0;
      pend_data   <= 1'b0;
    end else begin
      if (wr) begin
        case (offset)
          3'd0:    x_reg[7:0] <= BUS_DATA_IN;
          3'd1:    x_reg[8]   <= BUS_DATA_IN[0];
          3'd2:    y_reg      <= BUS_DATA_IN;
          3'd4:    fg_reg     <= BUS_DATA_IN;
          3'd5:    bg_reg     <= BUS_DATA_IN;
          default: ;
        endcase
      end
      pend_valid <= pix_wr && coord_ok;
      if (pix_wr && coord_ok) begin
        pend_addr <= {y_reg, x_reg};
        pend_data <= BUS_DATA_IN[0];
      end
      // ERR is cleared one cycle after the status byte is returned; a new error wins
      status_rd_q <= rd && (offset == 3'd7);
      if ((pix_wr || rb_rd) && !coord_ok)
        err <= 1'b1;
      else if (status_rd_q)
        err <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      fill_x   <= 9'd0;
      fill_y   <= 8'd0;
      fill_val <= 1'b0;
    end else begin
      state <= state_next;
      if (start_fill) begin
        fill_x   <= 9'd0;
        fill_y   <= 8'd0;
        fill_val <= BUS_DATA_IN[1];
      end else if (fill_we) begin
        if (fill_x == X_LAST) begin
          fill_x <= 9'd0;
          fill_y <= fill_y + 8'd1;
        end else begin
          fill_x <= fill_x + 9'd1;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    fill_we    = 1'b0;
    FILL_DONE  = 1'b0;
    case (state)
      IDLE: if (start_fill) state_next = RUN;
      RUN: begin
        if (!pend_valid && !rb_port) begin
          fill_we = 1'b1;
          if (fill_x == X_LAST && fill_y == Y_LAST) state_next = DONE;
        end
      end
      DONE: begin
        FILL_DONE  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending CPU write owns port A first, then a readback, then the fill engine
  always_comb begin
    FB_WE   = 1'b0;
    FB_ADDR = 17'd0;
    FB_DATA = 1'b0;
    if (pend_valid) begin
      FB_WE   = 1'b1;
      FB_ADDR = pend_addr;
      FB_DATA = pend_data;
    end else if (rb_port) begin
      FB_ADDR = {y_reg, x_reg};
    end else if (fill_we) begin
      FB_WE   = 1'b1;
      FB_ADDR = {fill_y, fill_x};
      FB_DATA = fill_val;
    end
  end

endmodule

// File: tb/tb_vga_fb_controller.sv
// Directed self-checking bench for vga_fb_controller (default build, FB_READBACK_EN undefined).
module tb_vga_fb_controller;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  BUS_ADDR = 8'h00;
  logic [7:0]  BUS_DATA_IN = 8'h00;
  logic        BUS_WE = 1'b0;
  logic        BUS_RE = 1'b0;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_DATA_OE;
  logic [16:0] FB_ADDR;
  logic        FB_DATA;
  logic        FB_WE;
  logic        FB_RD_DATA = 1'b0;
  logic [15:0] CONFIG_COLOURS;
  logic        FILL_DONE;

  int vectors = 0;
  int miscompares = 0;

  // fill monitor state
  logic        mon_en = 1'b0;
  logic [8:0]  mon_x = 9'd0;
  logic [7:0]  mon_y = 8'd0;
  logic        fill_val_exp = 1'b0;
  logic        cpu_exp = 1'b0;
  logic [16:0] cpu_addr = 17'd0;
  logic        cpu_data = 1'b0;
  logic [16:0] last_addr = 17'd0;
  int fill_wr_cnt = 0, seq_bad = 0, cpu_wr_cnt = 0, cpu_bad = 0;
  int done_cnt = 0, run_cycles = 0, total_done = 0;

  vga_fb_controller dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_WE(BUS_WE), .BUS_RE(BUS_RE), .BUS_DATA_OUT(BUS_DATA_OUT), .BUS_DATA_OE(BUS_DATA_OE),
    .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WE(FB_WE), .FB_RD_DATA(FB_RD_DATA),
    .CONFIG_COLOURS(CONFIG_COLOURS), .FILL_DONE(FILL_DONE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (FILL_DONE === 1'b1) total_done++;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (FILL_DONE === 1'b1) done_cnt++;
      else if (done_cnt == 0) run_cycles++;
      if (cpu_exp) begin
        if (FB_WE === 1'b1 && FB_ADDR === cpu_addr && FB_DATA === cpu_data) cpu_wr_cnt++;
        else cpu_bad++;
      end else if (FB_WE === 1'b1) begin
        if (FB_ADDR !== {mon_y, mon_x} || FB_DATA !== fill_val_exp) seq_bad++;
        fill_wr_cnt++;
        last_addr = FB_ADDR;
        if (mon_x == 9'd319) begin
          mon_x = 9'd0;
          mon_y = mon_y + 8'd1;
        end else begin
          mon_x = mon_x + 9'd1;
        end
      end
    end
  end

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge CLK); #1;
    BUS_ADDR = a; BUS_DATA_IN = d; BUS_WE = 1'b1;
    @(posedge CLK); #1;
    BUS_WE = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d, output logic oe);
    @(posedge CLK); #1;
    BUS_ADDR = a; BUS_RE = 1'b1;
    @(posedge CLK); #1;
    BUS_RE = 1'b0;
    d  = BUS_DATA_OUT;
    oe = BUS_DATA_OE;
  endtask

  task automatic clear_monitor(input logic fv);
    mon_x = 9'd0; mon_y = 8'd0; fill_val_exp = fv;
    fill_wr_cnt = 0; seq_bad = 0; cpu_wr_cnt = 0; cpu_bad = 0;
    done_cnt = 0; run_cycles = 0; last_addr = 17'd0;
  endtask

  task automatic cpu_pixel(input logic [8:0] x, input logic [7:0] y, input logic d);
    bus_write(8'hB0, x[7:0]);
    bus_write(8'hB1, {7'b0, x[8]});
    bus_write(8'hB2, y);
    cpu_addr = {y, x};
    cpu_data = d;
    bus_write(8'hB3, {7'b0, d});
    cpu_exp = 1'b1;
    @(posedge CLK); #1;
    cpu_exp = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic oe;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    vectors++;
    if ({BUS_DATA_OUT, BUS_DATA_OE, FB_WE, FB_ADDR, FB_DATA, FILL_DONE} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got out=%h oe=%b we=%b addr=%h data=%b done=%b, want all 0",
               BUS_DATA_OUT, BUS_DATA_OE, FB_WE, FB_ADDR, FB_DATA, FILL_DONE);
    end
    vectors++;
    if (CONFIG_COLOURS !== 16'hFF00) begin
      miscompares++;
      $display("FAIL reset_colours: got %h want ff00", CONFIG_COLOURS);
    end
    bus_read(8'hB4, d, oe);
    vectors++;
    if (d !== 8'hFF || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL read_fg: got %h oe=%b want ff oe=1", d, oe);
    end
    bus_read(8'hB5, d, oe);
    vectors++;
    if (d !== 8'h00 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL read_bg: got %h oe=%b want 00 oe=1", d, oe);
    end
    bus_read(8'hB7, d, oe);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_status: got %h want 00", d);
    end
  endtask

  task automatic test_colours();
    logic [7:0] d;
    logic oe;
    bus_write(8'hB4, 8'h5A);
    vectors++;
    if (CONFIG_COLOURS !== 16'h5A00) begin
      miscompares++;
      $display("FAIL fg_write: got %h want 5a00", CONFIG_COLOURS);
    end
    bus_write(8'hB5, 8'hC3);
    vectors++;
    if (CONFIG_COLOURS !== 16'h5AC3) begin
      miscompares++;
      $display("FAIL bg_write: got %h want 5ac3", CONFIG_COLOURS);
    end
    bus_read(8'hB5, d, oe);
    vectors++;
    if (d !== 8'hC3 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL bg_readback: got %h oe=%b want c3 oe=1", d, oe);
    end
    @(posedge CLK); #1;
    vectors++;
    if (BUS_DATA_OE !== 1'b0 || BUS_DATA_OUT !== 8'h00) begin
      miscompares++;
      $display("FAIL oe_one_cycle: got oe=%b out=%h want oe=0 out=00", BUS_DATA_OE, BUS_DATA_OUT);
    end
    bus_write(8'hB4, 8'hFF);
    bus_write(8'hB5, 8'h00);
  endtask

  task automatic test_pixel_write();
    logic [7:0] d;
    logic oe;
    bus_write(8'hB0, 8'h3F);
    bus_write(8'hB1, 8'h01);
    bus_write(8'hB2, 8'h10);
    vectors++;
    if (FB_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL coord_no_we: got we=%b want 0", FB_WE);
    end
    bus_write(8'hB3, 8'h01);
    vectors++;
    if (FB_WE !== 1'b1 || FB_ADDR !== 17'h0213F || FB_DATA !== 1'b1) begin
      miscompares++;
      $display("FAIL pixel_write: got we=%b addr=%h data=%b want we=1 addr=0213f data=1",
               FB_WE, FB_ADDR, FB_DATA);
    end
    @(posedge CLK); #1;
    vectors++;
    if (FB_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL pixel_single: got we=%b want 0", FB_WE);
    end
    bus_read(8'hB1, d, oe);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++;
      $display("FAIL read_x8: got %h want 01", d);
    end
  endtask

  task automatic test_decode();
    logic [7:0] d;
    logic oe;
    bus_write(8'hB8, 8'h77);
    bus_write(8'hAC, 8'h11);
    vectors++;
    if (CONFIG_COLOURS !== 16'hFF00 || FB_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL decode_ignore: got colours=%h we=%b want ff00 we=0", CONFIG_COLOURS, FB_WE);
    end
    bus_read(8'hB0, d, oe);
    vectors++;
    if (d !== 8'h3F) begin
      miscompares++;
      $display("FAIL decode_x_kept: got %h want 3f", d);
    end
    bus_read(8'hB9, d, oe);
    vectors++;
    if (d !== 8'h00 || oe !== 1'b0) begin
      miscompares++;
      $display("FAIL decode_read_ignore: got %h oe=%b want 00 oe=0", d, oe);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d;
    logic oe;
    bus_write(8'hB0, 8'h40);
    bus_write(8'hB1, 8'h01);
    bus_write(8'hB3, 8'h01);
    vectors++;
    if (FB_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_dropped: got we=%b want 0", FB_WE);
    end
    bus_read(8'hB7, d, oe);
    vectors++;
    if (d !== 8'h02 || oe !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_err_set: got %h oe=%b want 02 oe=1", d, oe);
    end
    bus_read(8'hB7, d, oe);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL oor_err_clear: got %h want 00", d);
    end
  endtask

  task automatic test_fill_with_cpu_writes();
    logic [7:0] d;
    logic oe;
    clear_monitor(1'b1);
    bus_write(8'hB6, 8'h03);
    mon_en = 1'b1;
    bus_read(8'hB7, d, oe);
    vectors++;
    if (d !== 8'h01) begin
      miscompares++;
      $display("FAIL fill_busy: got %h want 01", d);
    end
    cpu_pixel(9'd5, 8'd7, 1'b0);
    cpu_pixel(9'd319, 8'd239, 1'b0);
    cpu_pixel(9'd100, 8'd200, 1'b1);
    bus_write(8'hB6, 8'h01);
    for (int i = 0; i < 80000 && done_cnt == 0; i++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (done_cnt !== 1) begin
      miscompares++;
      $display("FAIL fill_done_pulse: got %0d pulses want 1", done_cnt);
    end
    vectors++;
    if (fill_wr_cnt !== 76800 || seq_bad !== 0) begin
      miscompares++;
      $display("FAIL fill_sequence: got %0d writes %0d bad want 76800 writes 0 bad", fill_wr_cnt, seq_bad);
    end
    vectors++;
    if (last_addr !== {8'd239, 9'd319}) begin
      miscompares++;
      $display("FAIL fill_last_addr: got %h want %h", last_addr, {8'd239, 9'd319});
    end
    vectors++;
    if (cpu_wr_cnt !== 3 || cpu_bad !== 0) begin
      miscompares++;
      $display("FAIL cpu_during_fill: got %0d ok %0d bad want 3 ok 0 bad", cpu_wr_cnt, cpu_bad);
    end
    vectors++;
    if (run_cycles !== 76803) begin
      miscompares++;
      $display("FAIL fill_duration: got %0d cycles want 76803", run_cycles);
    end
    mon_en = 1'b0;
    bus_read(8'hB7, d, oe);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL fill_idle_status: got %h want 00", d);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] d;
    logic oe;
    int done_before;
    bus_write(8'hB4, 8'h5A);
    clear_monitor(1'b0);
    bus_write(8'hB6, 8'h01);
    mon_en = 1'b1;
    repeat (200) @(posedge CLK);
    vectors++;
    if (fill_wr_cnt !== 200 || seq_bad !== 0) begin
      miscompares++;
      $display("FAIL prefill_sequence: got %0d writes %0d bad want 200 writes 0 bad", fill_wr_cnt, seq_bad);
    end
    mon_en = 1'b0;
    done_before = total_done;
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    vectors++;
    if (FB_WE !== 1'b0 || CONFIG_COLOURS !== 16'hFF00) begin
      miscompares++;
      $display("FAIL abort_state: got we=%b colours=%h want we=0 colours=ff00", FB_WE, CONFIG_COLOURS);
    end
    repeat (10) @(posedge CLK);
    #1;
    vectors++;
    if (total_done !== done_before || FB_WE !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d extra pulses we=%b want 0 pulses we=0",
               total_done - done_before, FB_WE);
    end
    bus_read(8'hB0, d, oe);
    vectors++;
    if (d !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_x_reset: got %h want 00", d);
    end
    clear_monitor(1'b0);
    bus_write(8'hB6, 8'h01);
    mon_en = 1'b1;
    repeat (50) @(posedge CLK);
    vectors++;
    if (fill_wr_cnt !== 50 || seq_bad !== 0) begin
      miscompares++;
      $display("FAIL restart_sequence: got %0d writes %0d bad want 50 writes 0 bad", fill_wr_cnt, seq_bad);
    end
    mon_en = 1'b0;
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_colours();
    test_pixel_write();
    test_decode();
    test_out_of_range();
    test_fill_with_cpu_writes();
    test_reset_mid_fill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
